// File: rtl/gates_pkg.sv
// Shared constants for the gates library: default operand width and the
// reset value for NAND outputs (NAND of all-zero operands is all ones).
package gates_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

  // Per-bit reset value; replicate to the instance width.
  localparam logic NAND_RST_BIT = 1'b1;

  function automatic int unsigned checked_width(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/nand_reg_stage.sv
// WIDTH-bit output register with load enable, valid flag and synchronous
// active-low reset to the NAND reset value.
module nand_reg_stage
  import gates_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= {WIDTH{NAND_RST_BIT}};
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/nand_gate.sv
// Bitwise 2-input NAND with a combinational result and an optional
// registered copy qualified by a valid flag.
module nand_gate
  import gates_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_q,
  output logic             out_valid
);

  assign C = ~(A & B);

  generate
    if (REG_OUT) begin : g_reg
      nand_reg_stage #(
        .WIDTH(checked_width(WIDTH))
      ) u_reg_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (C),
        .load (in_valid),
        .q    (C_q),
        .valid(out_valid)
      );
    end else begin : g_comb
      // Clock and reset have no role without the register stage.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign C_q       = C;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_nand_gate.sv
// Scoreboard bench for nand_gate: WIDTH=1 and WIDTH=8 registered instances
// plus a WIDTH=4 combinational-only instance.
module tb_nand_gate;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a1, b1, iv1;
  logic       c1, cq1, ov1;
  logic [7:0] a8, b8;
  logic       iv8;
  logic [7:0] c8, cq8;
  logic       ov8;
  logic [3:0] a4, b4;
  logic       iv4;
  logic [3:0] c4, cq4;
  logic       ov4;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  typedef struct {
    logic       v1;
    logic       q1;
    logic       v8;
    logic [7:0] q8;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  nand_gate #(.WIDTH(1), .REG_OUT(1'b1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(iv1),
    .C(c1), .C_q(cq1), .out_valid(ov1)
  );

  nand_gate #(.WIDTH(8), .REG_OUT(1'b1)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(iv8),
    .C(c8), .C_q(cq8), .out_valid(ov8)
  );

  nand_gate #(.WIDTH(4), .REG_OUT(1'b0)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .in_valid(iv4),
    .C(c4), .C_q(cq4), .out_valid(ov4)
  );

  // Reference NAND from the truth table: a bit is 0 only when both operands are 1.
  function automatic logic [7:0] ref_nand(input logic [7:0] a, input logic [7:0] b,
                                          input int unsigned w);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      r[i] = (a[i] === 1'b1 && b[i] === 1'b1) ? 1'b0 : 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: at every edge records what each register should show afterwards.
  logic       m_q1 = 1'b1;
  logic [7:0] m_q8 = 8'hFF;
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_q1 = 1'b1;
      m_q8 = 8'hFF;
      e.v1 = 1'b0;
      e.v8 = 1'b0;
    end else begin
      e.v1 = iv1;
      e.v8 = iv8;
      if (iv1) m_q1 = ref_nand({7'd0, a1}, {7'd0, b1}, 1);
      if (iv8) m_q8 = ref_nand(a8, b8, 8);
    end
    e.q1 = m_q1;
    e.q8 = m_q8;
    sb.push_back(e);
  end

  // Monitor: registered outputs are presented every cycle, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("w1_out_valid", {31'd0, ov1}, {31'd0, e.v1});
      check("w1_C_q", {31'd0, cq1}, {31'd0, e.q1});
      check("w8_out_valid", {31'd0, ov8}, {31'd0, e.v8});
      check("w8_C_q", {24'd0, cq8}, {24'd0, e.q8});
    end
  end

  task automatic comb_checks();
    #1;
    check("w1_C", {31'd0, c1}, {31'd0, ref_nand({7'd0, a1}, {7'd0, b1}, 1)});
    check("w8_C", {24'd0, c8}, {24'd0, ref_nand(a8, b8, 8)});
  endtask

  task automatic drive(input logic r, input logic v1, input logic ia, input logic ib,
                       input logic v8, input logic [7:0] xa, input logic [7:0] xb);
    @(negedge clk);
    rst_n = r;
    iv1 = v1; a1 = ia; b1 = ib;
    iv8 = v8; a8 = xa; b8 = xb;
    comb_checks();
  endtask

  task automatic check_w4(input logic [3:0] xa, input logic [3:0] xb, input logic v);
    logic [3:0] e;
    a4 = xa; b4 = xb; iv4 = v;
    #1;
    e = ref_nand({4'd0, xa}, {4'd0, xb}, 4);
    check("w4_C", {28'd0, c4}, {28'd0, e});
    check("w4_C_q", {28'd0, cq4}, {28'd0, e});
    check("w4_out_valid", {31'd0, ov4}, {31'd0, v});
  endtask

  initial begin
    logic [1:0] ab;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    a4 = '0; b4 = '0; iv4 = 1'b0;

    // Reset held for two edges with valid input present; C stays combinational.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);

    // WIDTH=1 truth table, each pattern held one 10 ns period.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      drive(1'b1, 1'b1, ab[1], ab[0], 1'b0, 8'h00, 8'h00);
    end

    // Latency: valid 1&1 then an idle cycle that must hold C_q.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    // WIDTH=8 directed vector.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 8'hCC);
    check("w8_C_F0_CC", {24'd0, c8}, 32'h3F);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Mid-stream reset for one edge, then streaming resumes.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h0F);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 8'hFF);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hF3);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 8'($urandom), 8'($urandom));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Combinational-only instance.
    check_w4(4'hA, 4'h6, 1'b1);
    check_w4(4'hA, 4'h6, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check_w4(4'($urandom), 4'($urandom), 1'($urandom));
    end

    @(negedge clk);
    if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nand_gate.md
Name: nand_gate

Overview:
- Bitwise 2-input NAND block: combinational result C = ~(A & B), plus a registered copy with a valid flag for pipelined users.
- Basic logic primitive in the gates library.
- Instantiated wherever a NAND is needed, either standalone (WIDTH=1) or as a vector bank.
- The combinational path keeps the primitive usable without a clock; the registered path provides a timing-clean output.

Parameters:
- WIDTH, 1, bit width of A, B, C and C_q (must be >= 1).
- REG_OUT, 1, 1 = instantiate the C_q/out_valid register stage; 0 = C_q tied to C and out_valid tied to in_valid.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low (sampled on rising clk edge).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  qualifies A/B for the registered path.
- C  output  WIDTH  combinational NAND, C = ~(A & B).
- C_q  output  WIDTH  registered NAND of the last accepted A/B.
- out_valid  output  1  C_q holds a result captured on the previous cycle.

Behaviour:
- C is purely combinational, bitwise: C[i] = ~(A[i] & B[i]). No dependence on clk or rst_n.
  - Per-bit truth table: 00->1, 01->1, 10->1, 11->0.
- C must settle within the same delta after A/B change; no latches.
- Registered path (REG_OUT=1), evaluated on each rising clk:
  - rst_n==0: C_q <= all ones (the NAND of all-zero operands), out_valid <= 0. Reset overrides in_valid.
  - rst_n==1 and in_valid==1: C_q <= ~(A & B), out_valid <= 1.
  - rst_n==1 and in_valid==0: C_q holds its value, out_valid <= 0.
- Latency of the registered path is exactly 1 cycle. Back-to-back in_valid is accepted every cycle; there is no backpressure.
- Reset asserted mid-stream: the result pending for the next edge is discarded, and out_valid is 0 on the cycle after the reset edge.
- X/Z on A/B propagates per standard 4-state semantics, except that a 0 on either operand bit forces that C bit to 1.
- REG_OUT=0: C_q = C and out_valid = in_valid combinationally; clk and rst_n are unused.

Decomposition:
- Shared package gates_pkg: default WIDTH constant and the reset value constant for the NAND output (all ones).
- One natural sub-module, nand_reg_stage: a WIDTH-bit register with sync active-low reset, load enable and valid flag. The top instantiates it under a REG_OUT generate branch.
- The combinational NAND stays in the top.

Test Plan:
- WIDTH=1 truth table: A,B = 0,0 / 0,1 / 1,0 / 1,1, each held 10 ns -> C = 1 / 1 / 1 / 0.
- Reset: rst_n=0 for 2 clk with in_valid=1, A=B=1 -> C_q=1, out_valid=0; C=0 throughout (combinational path unaffected).
- Latency: after reset release, in_valid=1 with A=B=1 at edge n -> C_q=0 and out_valid=1 after edge n; in_valid=0 at edge n+1 -> C_q stays 0, out_valid=0.
- WIDTH=8: A=8'hF0, B=8'hCC -> C=8'h3F combinationally, and C_q=8'h3F one cycle after in_valid.
- Mid-stream reset: streaming in_valid=1 with rst_n pulled low for one edge -> C_q=all ones and out_valid=0 after that edge; the next valid input resumes with normal 1-cycle latency.
- REG_OUT=0, WIDTH=4: A=4'hA, B=4'h6 -> C=C_q=4'hD, and out_valid tracks in_valid with no clock.
